mio_rst_seq: RTL



---
 rtl/mio_rst_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mio_rst_seq.sv
// Reset sequencer: synchronises reset_n, holds for a settle time, then releases
// NUM_DOMAINS active-low resets in index order and flags completion.
//
// state   | meaning
// RESET   | reset_n asserted, everything held in reset
// SYNC    | waiting for the deassertion synchroniser to read 1
// HOLD    | settle time of HOLD_CYCLES before the first release
// RELEASE | releasing one domain every STAGE_GAP cycles
// DONE    | all domains released; sw_rst_req re-runs from HOLD
module mio_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   rst_done,
  output logic [2:0]             state_o
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE_DOM = NUM_DOMAINS'(1);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [NUM_DOMAINS-1:0] rst_nx;
  logic                   done_nx;
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= (sync << 1) | SYNC_STAGES'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RESET;
      cnt      <= '0;
      rst_n_o  <= '0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      rst_n_o  <= rst_nx;
      rst_done <= done_nx;
    end
  end

  // rst_n_o doubles as a thermometer index: the next domain is the lowest 0 bit.
  // After the last release the counter is loaded with 0 so DONE follows one edge later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rst_nx   = rst_n_o;
    done_nx  = rst_done;
    case (state)
      ST_RESET: begin
        state_nx = ST_SYNC;
        cnt_nx   = '0;
      end
      ST_SYNC: begin
        if (sync[SYNC_STAGES-1]) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nx = ST_RELEASE;
          rst_nx   = (rst_n_o << 1) | ONE_DOM;
          cnt_nx   = (&rst_nx) ? '0 : GAP_LD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_RELEASE: begin
        if (cnt == '0) begin
          if (&rst_n_o) begin
            state_nx = ST_DONE;
            done_nx  = 1'b1;
            cnt_nx   = '0;
          end else begin
            rst_nx = (rst_n_o << 1) | ONE_DOM;
            cnt_nx = (&rst_nx) ? '0 : GAP_LD;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LD;
          rst_nx   = '0;
          done_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = ST_RESET;
        cnt_nx   = '0;
        rst_nx   = '0;
        done_nx  = 1'b0;
      end
    endcase
  end

  assign state_o = state;

endmodule
